// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding and width helpers for reset_sequencer
package rst_seq_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HOLD,
      S_STAGGER,
      S_RUN
   } state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction
endpackage

// File: rtl/clk_divider.sv
// clk_divider: divides clk by 2*DIV_HALF and flags each rising edge of the divided clock
module clk_divider #(
   parameter int DIV_HALF = 1
) (
   input  logic clk,
   input  logic reset,
   output logic div_clk,
   output logic div_tick
);
   localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   logic [DW-1:0] r_cnt;
   logic          r_div;
   logic          r_tick;
   logic          w_last;
   assign w_last = (r_cnt == DW'(DIV_HALF - 1));
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_div  <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_last ? '0 : r_cnt + DW'(1);
         r_div  <= r_div ^ w_last;
         // tick rides along with the 0->1 toggle so it covers the first high cycle
         r_tick <= w_last & ~r_div;
      end
   end
   assign div_clk  = r_div;
   assign div_tick = r_tick;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: free-running counter, divided clock and staggered per-channel
// reset release with a soft-restart handshake
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int CNT_W    = 32,
   parameter int PRE_CYC  = 4,
   parameter int HOLD_CYC = 4,
   parameter int STAGGER  = 2,
   parameter int DIV_HALF = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart_req,
   output logic             restart_ack,
   output logic [N_CH-1:0]  rst_out,
   output logic             done,
   output logic             div_clk,
   output logic             div_tick,
   output logic [CNT_W-1:0] counter
);
   localparam int SPAN = (N_CH - 1) * STAGGER;
   localparam int CW   = clog2(max3(PRE_CYC, HOLD_CYC, SPAN)) + 1;
   localparam bit SIMUL = (STAGGER == 0) || (N_CH == 1);
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [N_CH-1:0]  r_rst;
   logic             r_done;
   logic             r_ack;
   logic [CNT_W-1:0] r_counter;
   logic [CW-1:0]    w_nxt;
   assign w_nxt = r_cnt + CW'(1);
   clk_divider #(.DIV_HALF(DIV_HALF)) u_div (
      .clk      (clk),
      .reset    (reset),
      .div_clk  (div_clk),
      .div_tick (div_tick)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_rst     <= '0;
         r_done    <= 1'b0;
         r_ack     <= 1'b0;
         r_counter <= '0;
      end else begin
         r_counter <= r_counter + CNT_W'(1);
         r_ack     <= 1'b0;
         case (r_state)
            // r_cnt marks the single post-reset IDLE cycle
            S_IDLE: begin
               if (r_cnt == '0) begin
                  r_cnt <= CW'(1);
               end else begin
                  r_cnt <= '0;
                  if (PRE_CYC == 0) begin
                     r_state <= S_HOLD;
                     r_rst   <= '1;
                  end else begin
                     r_state <= S_PRE;
                  end
               end
            end
            S_PRE: begin
               if (r_cnt == CW'(PRE_CYC - 1)) begin
                  r_cnt   <= '0;
                  r_state <= S_HOLD;
                  r_rst   <= '1;
               end else begin
                  r_cnt <= w_nxt;
               end
            end
            S_HOLD: begin
               if (r_cnt == CW'(HOLD_CYC - 1)) begin
                  r_cnt <= '0;
                  if (SIMUL) begin
                     r_rst   <= '0;
                     r_state <= S_RUN;
                     r_done  <= 1'b1;
                  end else begin
                     r_rst[0] <= 1'b0;
                     r_state  <= S_STAGGER;
                  end
               end else begin
                  r_cnt <= w_nxt;
               end
            end
            S_STAGGER: begin
               r_cnt <= w_nxt;
               for (int i = 1; i < N_CH; i++)
                  if (w_nxt == CW'(i * STAGGER)) r_rst[i] <= 1'b0;
               if (w_nxt == CW'(SPAN)) begin
                  r_state <= S_RUN;
                  r_done  <= 1'b1;
               end
            end
            S_RUN: begin
               if (restart_req) begin
                  r_ack   <= 1'b1;
                  r_rst   <= '1;
                  r_done  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_HOLD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign restart_ack = r_ack;
   assign rst_out     = r_rst;
   assign done        = r_done;
   assign counter     = r_counter;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench driving two sequencer instances with directed phases
module tb_reset_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        restart_req = 1'b0;
   logic        ack_a, done_a, dclk_a, dtick_a;
   logic [3:0]  rst_a;
   logic [31:0] cnt_a;
   logic        ack_b, done_b, dclk_b, dtick_b;
   logic [3:0]  rst_b;
   logic [3:0]  cnt_b;
   typedef struct packed {
      logic [3:0]  rst;
      logic        done;
      logic        ack;
      logic [31:0] cnt;
      logic        dclk;
      logic        dtick;
      logic [3:0]  cnt4;
      logic        dclk3;
      logic        dtick3;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   reset_sequencer dut_a (
      .clk         (clk),
      .reset       (reset),
      .restart_req (restart_req),
      .restart_ack (ack_a),
      .rst_out     (rst_a),
      .done        (done_a),
      .div_clk     (dclk_a),
      .div_tick    (dtick_a),
      .counter     (cnt_a)
   );
   reset_sequencer #(.CNT_W(4), .DIV_HALF(3)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .restart_req (restart_req),
      .restart_ack (ack_b),
      .rst_out     (rst_b),
      .done        (done_b),
      .div_clk     (dclk_b),
      .div_tick    (dtick_b),
      .counter     (cnt_b)
   );
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", n, act, req, $time);
      end
   endtask
   // expected outputs after the coming edge; e = edge index since reset release, h = hold-entry edge
   task automatic cyc(input logic r, input logic rq, input int e, input int h, input logic a);
      exp_t x;
      int   k;
      reset = r;
      restart_req = rq;
      x = '0;
      if (!r) begin
         k = e - h;
         for (int i = 0; i < 4; i++) x.rst[i] = (e >= h) && (k < 4 + 2 * i);
         x.done   = (e >= h) && (k >= 10);
         x.ack    = a;
         x.cnt    = 32'(e + 1);
         x.dclk   = ((e + 1) % 2) == 1;
         x.dtick  = (e % 2) == 0;
         x.cnt4   = 4'((e + 1) % 16);
         x.dclk3  = (((e + 1) / 3) % 2) == 1;
         x.dtick3 = ((e + 1) % 6) == 3;
      end
      q.push_back(x);
      @(negedge clk);
   endtask
   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("rst_out", 32'(rst_a), 32'(x.rst));
            chk("done", 32'(done_a), 32'(x.done));
            chk("restart_ack", 32'(ack_a), 32'(x.ack));
            chk("counter", cnt_a, x.cnt);
            chk("div_clk", 32'(dclk_a), 32'(x.dclk));
            chk("div_tick", 32'(dtick_a), 32'(x.dtick));
            chk("b_rst_out", 32'(rst_b), 32'(x.rst));
            chk("b_done", 32'(done_b), 32'(x.done));
            chk("b_restart_ack", 32'(ack_b), 32'(x.ack));
            chk("b_counter4", 32'(cnt_b), 32'(x.cnt4));
            chk("b_div_clk3", 32'(dclk_b), 32'(x.dclk3));
            chk("b_div_tick3", 32'(dtick_b), 32'(x.dtick3));
         end
      end
   end
   initial begin : guard
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin : stim
      @(negedge clk);
      // phase A: power-on sequence, then a one-cycle restart pulse at edge 30
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int e = 0; e <= 45; e++) cyc(0, e == 30, e, (e >= 30) ? 30 : 5, e == 30);
      // phase B: restart_req held from edge 6 to 20; accepted on the first edge sampled in RUN
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int e = 0; e <= 30; e++) cyc(0, (e >= 6) && (e <= 20), e, (e >= 16) ? 16 : 5, e == 16);
      // phase C: reset together with restart_req mid-stagger, then a full fresh sequence
      cyc(1, 0, 0, 0, 0);
      for (int e = 0; e <= 10; e++) cyc(0, 0, e, 5, 0);
      cyc(1, 1, 0, 0, 0);
      for (int e = 0; e <= 20; e++) cyc(0, 0, e, 5, 0);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
